// File: rtl/adder_seq_pkg.sv
// adder_seq_pkg: shared types and constants for the slice-serial adder controller.
// Holds the controller state encoding, the default slice count and the derived operand width.
package adder_seq_pkg;
    localparam int NSLICE_DEF = 4;
    localparam int W = 2 * NSLICE_DEF;
    typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;
endpackage

// File: rtl/adder_2bit.sv
// adder_2bit: combinational 2-bit adder shared by the sequencer (lives outside adder_seq_ctrl).
// Ports: a, b - 2-bit addends; y - 3-bit sum including carry-out.
module adder_2bit (
    input  logic [1:0] a,
    input  logic [1:0] b,
    output logic [2:0] y
);
    assign y = {1'b0, a} + {1'b0, b};
endmodule

// File: rtl/adder_seq_ctrl_arbiter.sv
// rr_arbiter_2: two-requester grant logic for adder_seq_ctrl.
// Ports: clk, rst_n (async active-low); valid0/valid1 - requests; enable - grant is being
// consumed this cycle; grant - one-hot (or zero when nothing is valid).
// Macro ADDER_SEQ_RR_EN: defined -> round-robin with a last-grant register (reset to 1 so
// requester 0 wins the first contest); undefined -> fixed priority, requester 0 first.
module rr_arbiter_2 (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       valid0,
    input  logic       valid1,
    input  logic       enable,
    output logic [1:0] grant
);
`ifdef ADDER_SEQ_RR_EN
    logic last;
    always_comb begin
        grant = {valid1, valid0};
        if (valid0 && valid1)
            grant = last ? 2'b01 : 2'b10;
    end
    // Any non-zero grant while enabled is a transfer, so remember who won.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            last <= 1'b1;
        else if (enable && |grant)
            last <= grant[1];
    end
`else
    logic unused;
    assign unused = &{1'b0, clk, rst_n, enable};
    assign grant = {valid1 && !valid0, valid0};
`endif
endmodule

// File: rtl/adder_seq_ctrl.sv
// adder_seq_ctrl: arbitrates two operand requesters and adds W-bit operands 2 bits per cycle
// through an external shared 2-bit adder.
// Ports: clk, rst_n (async active-low);
//   req0_/req1_ valid, a, b (in), ready (out) - operand handshakes;
//   add_a, add_b (out), add_y (in) - shared 2-bit adder, add_a/add_b zero outside CALC;
//   res_valid, res_id, res_sum (out), res_ready (in) - result handshake, sum is W+1 bits.
// Macro ADDER_SEQ_RR_EN selects round-robin arbitration (see rr_arbiter_2); default is fixed
// priority to requester 0.
// Timing: accept at edge t, slices at edges t+1..t+NSLICE, res_valid from the cycle that
// begins at edge t+NSLICE (cycle t+NSLICE+1).
module adder_seq_ctrl
    import adder_seq_pkg::*;
#(
    parameter  int NSLICE = NSLICE_DEF,
    localparam int OPW    = 2 * NSLICE
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           req0_valid,
    input  logic [OPW-1:0] req0_a,
    input  logic [OPW-1:0] req0_b,
    output logic           req0_ready,
    input  logic           req1_valid,
    input  logic [OPW-1:0] req1_a,
    input  logic [OPW-1:0] req1_b,
    output logic           req1_ready,
    output logic [1:0]     add_a,
    output logic [1:0]     add_b,
    input  logic [2:0]     add_y,
    output logic           res_valid,
    output logic           res_id,
    output logic [OPW:0]   res_sum,
    input  logic           res_ready
);
    localparam int CW = $clog2(NSLICE + 1);
    state_t         state, state_n;
    logic [1:0]     grant;
    logic [OPW-1:0] op_a, op_b;
    logic [CW-1:0]  cnt;
    logic           carry;
    logic [2:0]     sum3;
    logic           xfer, last_slice;

    rr_arbiter_2 u_arb (
        .clk    (clk),
        .rst_n  (rst_n),
        .valid0 (req0_valid),
        .valid1 (req1_valid),
        .enable (state == IDLE),
        .grant  (grant)
    );

    assign req0_ready = (state == IDLE) && grant[0];
    assign req1_ready = (state == IDLE) && grant[1];
    assign xfer       = (req0_valid && req0_ready) || (req1_valid && req1_ready);
    assign add_a      = (state == CALC) ? op_a[{cnt, 1'b0} +: 2] : 2'b00;
    assign add_b      = (state == CALC) ? op_b[{cnt, 1'b0} +: 2] : 2'b00;
    assign sum3       = add_y + {2'b00, carry};
    assign last_slice = cnt == CW'(NSLICE - 1);
    assign res_valid  = state == DONE;

    always_comb begin
        state_n = state;
        case (state)
            IDLE:    state_n = xfer ? CALC : IDLE;
            CALC:    state_n = last_slice ? DONE : CALC;
            DONE:    state_n = res_ready ? IDLE : DONE;
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            op_a    <= '0;
            op_b    <= '0;
            res_id  <= 1'b0;
            res_sum <= '0;
            carry   <= 1'b0;
            cnt     <= '0;
        end else begin
            state <= state_n;
            if (xfer) begin
                // grant is one-hot in IDLE, so req1_ready alone identifies the winner
                op_a    <= req1_ready ? req1_a : req0_a;
                op_b    <= req1_ready ? req1_b : req0_b;
                res_id  <= req1_ready;
                res_sum <= '0;
                carry   <= 1'b0;
                cnt     <= '0;
            end else if (state == CALC) begin
                res_sum[{cnt, 1'b0} +: 2] <= sum3[1:0];
                carry <= sum3[2];
                cnt   <= cnt + 1'b1;
                if (last_slice)
                    res_sum[OPW] <= sum3[2];
            end
        end
    end
endmodule
